// File: rtl/alu_pkg.sv
// Shared funct codes and multi-cycle unit state encoding for alu_mdu.
package alu_pkg;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply (shift-add) and, with ALU_MDU_DIVU_EN, restoring divide into HI/LO.
// One partial step per cycle, WIDTH cycles per operation.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_MDU_DIVU_EN
    logic [WIDTH:0]   div_rem, div_diff;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        done    = 1'b0;
        // LO holds the unconsumed multiplier bits; product bits shift in from HI.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_MDU_DIVU_EN
        div_rem  = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, opnd_q};
`endif
        case (state_q)
            IDLE: begin
                if (start_mul) begin
                    state_d = MUL;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = op_b;
                    opnd_d  = op_a;
                end
`ifdef ALU_MDU_DIVU_EN
                else if (start_div) begin
                    state_d = DIV;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = op_a;
                    opnd_d  = op_b;
                end
`endif
            end
            MUL: begin
                hi_d  = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
`ifdef ALU_MDU_DIVU_EN
            DIV: begin
                // A zero divisor never borrows, giving all-ones quotient and remainder = dividend.
                if (!div_diff[WIDTH]) begin
                    hi_d = div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_rem[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

`ifndef ALU_MDU_DIVU_EN
    logic unused_start_div;
    assign unused_start_div = start_div;
`endif

endmodule

// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with iterative MULTU (and DIVU when ALU_MDU_DIVU_EN is defined).
// Single-cycle ops return one result per cycle; multi-cycle ops hold busy until done.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             out_valid,
    output logic             busy,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic signed [WIDTH-1:0] ONE = 1;

    logic                    md_busy, md_done, start_mul, start_div, accept;
    logic [WIDTH-1:0]        md_hi, md_lo;
    logic signed [WIDTH-1:0] a_s, b_s, add_res, sub_res;
    logic                    add_ovf, sub_ovf, slt_bit;
    logic [WIDTH-1:0]        dataOut_q, dataOut_d;
    logic                    out_valid_q, out_valid_d, overflow_q, overflow_d;

    assign accept  = in_valid & ~md_busy;
    assign a_s     = signed'(dataA);
    assign b_s     = signed'(dataB);
    assign add_res = a_s + b_s;
    assign sub_res = a_s + ~b_s + ONE;
    assign add_ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (add_res[WIDTH-1] != a_s[WIDTH-1]);
    assign sub_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (sub_res[WIDTH-1] != a_s[WIDTH-1]);
    // The overflow term corrects the sign of the difference when it wrapped.
    assign slt_bit = sub_res[WIDTH-1] ^ sub_ovf;

    always_comb begin
        dataOut_d   = dataOut_q;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        if (md_done) begin
            out_valid_d = 1'b1;
            dataOut_d   = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            case (Signal)
                F_AND: dataOut_d = dataA & dataB;
                F_OR:  dataOut_d = dataA | dataB;
                F_ADD: begin
                    dataOut_d  = add_res;
                    overflow_d = add_ovf;
                end
                F_SUB: begin
                    dataOut_d  = sub_res;
                    overflow_d = sub_ovf;
                end
                F_SLT:  dataOut_d = {{(WIDTH-1){1'b0}}, slt_bit};
                F_SRL:  dataOut_d = dataA >> dataB[SHW-1:0];
                F_MFHI: dataOut_d = md_hi;
                F_MFLO: dataOut_d = md_lo;
                F_MULTU: begin
                    start_mul   = 1'b1;
                    out_valid_d = 1'b0;
                end
`ifdef ALU_MDU_DIVU_EN
                F_DIVU: begin
                    start_div   = 1'b1;
                    out_valid_d = 1'b0;
                end
`endif
                default: dataOut_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOut_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dataOut_q   <= dataOut_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start_mul (start_mul),
        .start_div (start_div),
        .op_a      (dataA),
        .op_b      (dataB),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    assign dataOut   = dataOut_q;
    assign out_valid = out_valid_q;
    assign busy      = md_busy;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed scoreboard bench for alu_mdu (WIDTH=32); follows ALU_MDU_DIVU_EN for the DIVU steps.
module tb_alu_mdu;
    localparam int W = 32;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [5:0]   Signal;
    logic [W-1:0] dataA, dataB, dataOut;
    logic         out_valid, busy, overflow;

    typedef struct {
        string        tag;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .Signal    (Signal),
        .dataA     (dataA),
        .dataB     (dataB),
        .dataOut   (dataOut),
        .out_valid (out_valid),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock; any out_valid seen here must match the oldest scoreboard entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", dataOut, 'x);
            end else begin
                e = sb_q.pop_front();
                chk(e.tag, dataOut, e.data);
            end
        end
    endtask

    task automatic push(input string tag, input logic [W-1:0] data);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp);
        in_valid = 1'b1;
        Signal   = f;
        dataA    = a;
        dataB    = b;
        push(tag, exp);
        tick();
        chk({tag, "_valid"}, W'(out_valid), W'(1));
        in_valid = 1'b0;
    endtask

    // Issue a multi-cycle op and wait (bounded) for its completion pulse.
    task automatic multi(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int n;
        in_valid = 1'b1;
        Signal   = f;
        dataA    = a;
        dataB    = b;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, W'(busy), W'(1));
        push({tag, "_done_data"}, '0);
        n = 0;
        for (int i = 1; i <= W + 8; i++) begin
            tick();
            n = i;
            if (out_valid === 1'b1) break;
        end
        chk({tag, "_latency"}, W'(n), W'(W));
        chk({tag, "_busy_after"}, W'(busy), W'(0));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        Signal   = '0;
        dataA    = '0;
        dataB    = '0;
        tick();
        tick();
        chk("rst_dataOut", dataOut, '0);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_overflow", W'(overflow), W'(0));
        reset = 1'b0;
        tick();

        op("rst_mfhi", F_MFHI, '0, '0, '0);
        op("rst_mflo", F_MFLO, '0, '0, '0);

        op("add_ovf", F_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        chk("add_ovf_flag", W'(overflow), W'(1));
        tick();
        chk("add_pulse_low", W'(out_valid), W'(0));

        op("slt_neg", F_SLT, 32'h8000_0000, 32'h1, 32'h1);
        chk("slt_ovf_hold", W'(overflow), W'(1));
        op("slt_wrap", F_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0);
        op("sub", F_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        chk("sub_ovf_flag", W'(overflow), W'(0));
        op("srl", F_SRL, 32'hF000_0000, 32'd4, 32'h0F00_0000);
        op("srl_hi_bits", F_SRL, 32'h8000_0000, 32'h0000_0FFF, 32'h0000_0001);
        op("and", F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        op("or", F_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        op("unknown", 6'b111111, 32'h1234_5678, 32'h1, 32'h0);
        tick();

        // MULTU with an ADD request injected while busy; it must be dropped.
        in_valid = 1'b1;
        Signal   = F_MULTU;
        dataA    = 32'hFFFF_FFFF;
        dataB    = 32'hFFFF_FFFF;
        tick();
        chk("mul_busy", W'(busy), W'(1));
        in_valid = 1'b0;
        push("mul_done_data", '0);
        tick();
        tick();
        in_valid = 1'b1;
        Signal   = F_ADD;
        dataA    = 32'h1;
        dataB    = 32'h1;
        tick();
        in_valid = 1'b0;
        chk("mul_busy_ignore", W'(busy), W'(1));
        begin
            int n;
            n = 3;
            for (int i = 4; i <= W + 8; i++) begin
                tick();
                n = i;
                if (out_valid === 1'b1) break;
            end
            chk("mul_latency", W'(n), W'(W));
        end
        chk("mul_busy_after", W'(busy), W'(0));
        op("mfhi_mul", F_MFHI, '0, '0, 32'hFFFF_FFFE);
        op("mflo_mul", F_MFLO, '0, '0, 32'h0000_0001);

        multi("mul_small", F_MULTU, 32'd12345, 32'd6789);
        op("mflo_small", F_MFLO, '0, '0, 32'd83810205);
        op("mfhi_small", F_MFHI, '0, '0, 32'd0);

`ifdef ALU_MDU_DIVU_EN
        multi("div", F_DIVU, 32'd100, 32'd7);
        op("div_lo", F_MFLO, '0, '0, 32'd14);
        op("div_hi", F_MFHI, '0, '0, 32'd2);
        multi("div0", F_DIVU, 32'd100, 32'd0);
        op("div0_lo", F_MFLO, '0, '0, 32'hFFFF_FFFF);
        op("div0_hi", F_MFHI, '0, '0, 32'd100);
`else
        op("divu_off", F_DIVU, 32'd100, 32'd7, 32'h0);
        chk("divu_off_busy", W'(busy), W'(0));
        op("divu_off_hi", F_MFHI, '0, '0, 32'd0);
        op("divu_off_lo", F_MFLO, '0, '0, 32'd83810205);
`endif

        // Reset in the middle of a multiply aborts it with no completion pulse.
        in_valid = 1'b1;
        Signal   = F_MULTU;
        dataA    = 32'hDEAD_BEEF;
        dataB    = 32'h1234_5678;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("abort_busy_pre", W'(busy), W'(1));
        reset = 1'b1;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        tick();
        reset = 1'b0;
        op("abort_mfhi", F_MFHI, '0, '0, '0);
        op("abort_mflo", F_MFLO, '0, '0, '0);
        repeat (W + 4) tick();
        chk("sb_drained", W'(sb_q.size()), W'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, registered successor to the 1-bit ALU slice. Performs WIDTH-bit AND/OR/ADD/SUB/SLT/SRL in one cycle and unsigned multiply over WIDTH cycles into HI/LO registers, read back with MFHI/MFLO. Sits in the execute stage of the MIPS datapath and is driven by the R-type funct field. A valid/busy handshake stalls issue during multi-cycle operations.

## Interface
- WIDTH, 32, datapath width in bits (≥4, even)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation request; accepted only when busy=0
- Signal  in  6  funct code
- dataA  in  WIDTH  operand A / dividend / multiplicand
- dataB  in  WIDTH  operand B / divisor / multiplier / shift amount (low log2(WIDTH) bits)
- dataOut  out  WIDTH  registered result
- out_valid  out  1  one-cycle pulse: dataOut valid / multi-cycle op complete
- busy  out  1  multi-cycle op in progress; new requests ignored
- overflow  out  1  registered signed overflow of last ADD/SUB

## Operation
- Funct codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010.
- AND/OR bitwise; ADD/SUB modulo 2^WIDTH; SUB = A + ~B + 1.
- SLT: signed compare, dataOut = {WIDTH-1 zeros, A<B}, correct under overflow (uses sign XOR overflow).
- SRL: logical right shift of A by dataB[log2(WIDTH)-1:0].
- overflow updated only by ADD/SUB; holds otherwise.
- MULTU: shift-add, one partial product per cycle; {HI,LO} = A×B unsigned (2·WIDTH bits). dataOut = 0 on completion.
- MFHI/MFLO: single-cycle, dataOut = HI / LO.
- Unknown funct: dataOut = 0, out_valid still pulses.
- State machine: IDLE → MUL on accepted MULTU (→ DIV on DIVU when enabled); MUL/DIV → IDLE after WIDTH iteration cycles. busy = (state≠IDLE).
- in_valid while busy: ignored, no queueing, no out_valid.

## Timing
- Reset values: dataOut 0, out_valid 0, busy 0, overflow 0, HI 0, LO 0, state IDLE.
- Single-cycle ops: request sampled at edge t; dataOut/out_valid valid after edge t, out_valid low after edge t+1 unless another request.
- MULTU/DIVU accepted at edge t: busy high after edge t; HI/LO final and out_valid pulses after edge t+WIDTH; busy low after edge t+WIDTH; new request accepted at edge t+WIDTH+1 earliest.
- MFHI issued the cycle after out_valid returns the new HI.
- Reset mid-operation: immediately aborts, HI/LO cleared, no out_valid.
- Back-to-back single-cycle ops: one result per cycle.

## Configuration
- ALU_MDU_DIVU_EN defined: DIVU supported, restoring division, WIDTH cycles; LO = quotient, HI = remainder. Divide by zero: LO = all ones, HI = dataA, same latency.
- Not defined: DIVU treated as unknown funct (single cycle, dataOut 0, HI/LO unchanged, busy stays 0).

## Structure
- Package alu_pkg: funct localparams, state enum {IDLE, MUL, DIV}.
- Sub-module alu_muldiv: iteration counter, HI/LO, shift-add and restoring-divide datapath, busy/done; top holds single-cycle ops, output registers, and muxing.

## Test plan
- Reset then ADD A=0x7FFFFFFF B=1 -> dataOut 0x80000000, overflow 1, out_valid 1 cycle.
- SLT A=0x80000000 B=1 -> 1; SUB A=5 B=7 -> 0xFFFFFFFE, overflow 0; SRL A=0xF0000000 B=4 -> 0x0F000000.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> out_valid after 32 cycles; MFHI 0xFFFFFFFE, MFLO 0x00000001.
- ADD request during MULTU busy -> ignored, no extra out_valid, HI/LO unaffected.
- DIVU (macro on) A=100 B=7 -> LO 14, HI 2; B=0 -> LO 0xFFFFFFFF, HI 100; macro off -> dataOut 0 next cycle, busy 0.
- Reset asserted at cycle 10 of MULTU -> busy 0, MFHI/MFLO return 0, no out_valid.
